ahb_refill_ctrl: RTL and testbench

- AHB-Lite read-only master sequencer that refills one I-cache line on a miss.
- Accepts a miss address from the cache controller and issues one aligned INCRx read burst, with pipelined address and data phases.
- Captures each data beat under hready and hands words to the cache data array with a word index.
- Reports completion or bus error. Sits between the I-cache miss logic and the AHB bus.

---
 rtl/ahb_refill_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ahb_refill_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_refill_ctrl.sv
// ahb_refill_ctrl
// AHB-Lite read-only master that refills one I-cache line with a single
// aligned INCR4/8/16 burst. Address and data phases are pipelined; each beat
// is handed to the data array with its word index, and the burst ends with
// either a fill_done pulse (clean) or a fill_err pulse (ERROR response).
module ahb_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          miss_req,
    input  logic [ADDR_W-1:0]             miss_addr,
    output logic                          miss_ack,
    output logic                          busy,
    output logic [ADDR_W-1:0]             haddr,
    output logic [1:0]                    htrans,
    output logic [2:0]                    hburst,
    output logic [2:0]                    hsize,
    output logic                          hwrite,
    input  logic                          hready,
    input  logic                          hresp,
    input  logic [DATA_W-1:0]             hrdata,
    output logic                          fill_valid,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]             fill_data,
    output logic                          fill_done,
    output logic                          fill_err
);

    localparam int IW    = $clog2(LINE_WORDS);
    localparam int OFF_W = IW + 2;

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [IW-1:0]     LAST_BEAT   = IW'(LINE_WORDS - 1);
    localparam logic [IW-1:0]     ONE         = IW'(1);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_VAL = (LINE_WORDS == 16) ? 3'b111 :
                                        (LINE_WORDS == 8)  ? 3'b101 : 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IW-1:0]       acnt_q, acnt_d;
    logic [IW-1:0]       dcnt_q, dcnt_d;
    logic [IW-1:0]       acnt_inc;

    logic [ADDR_W-1:0]   haddr_d;
    logic [1:0]          htrans_d;
    logic                miss_ack_d;
    logic                fill_valid_d;
    logic [IW-1:0]       fill_idx_d;
    logic [DATA_W-1:0]   fill_data_d;
    logic                fill_done_d;
    logic                fill_err_d;

    // Beat n of the line lives at base + 4*n; the offset never carries out of
    // the aligned line, so OR-ing it in is equivalent to adding.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [IW-1:0]     n);
        return b | {{(ADDR_W - OFF_W){1'b0}}, n, 2'b00};
    endfunction

    assign acnt_inc = acnt_q + ONE;

    assign busy   = (state_q != S_IDLE);
    assign hburst = HBURST_VAL;
    assign hsize  = 3'b010;
    assign hwrite = 1'b0;

    // Next-state and next-output decode; every bus/fill output is registered.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        acnt_d       = acnt_q;
        dcnt_d       = dcnt_q;
        haddr_d      = haddr;
        htrans_d     = htrans;
        miss_ack_d   = 1'b0;
        fill_valid_d = 1'b0;
        fill_idx_d   = fill_idx;
        fill_data_d  = fill_data;
        fill_done_d  = 1'b0;
        fill_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                htrans_d = HTRANS_IDLE;
                if (miss_req) begin
                    base_d     = miss_addr & ~OFFSET_MASK;
                    haddr_d    = base_d;
                    htrans_d   = HTRANS_NONSEQ;
                    miss_ack_d = 1'b1;
                    acnt_d     = '0;
                    dcnt_d     = '0;
                    state_d    = S_ADDR;
                end
            end

            S_ADDR: begin
                // No data phase yet, so only hready matters here.
                if (hready) begin
                    acnt_d   = ONE;
                    haddr_d  = beat_addr(base_q, ONE);
                    htrans_d = HTRANS_SEQ;
                    state_d  = S_BURST;
                end
            end

            S_BURST, S_DRAIN: begin
                if (hresp) begin
                    // First ERROR cycle: cancel the pending address at once.
                    htrans_d = HTRANS_IDLE;
                    if (hready) begin
                        fill_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (hready) begin
                    fill_valid_d = 1'b1;
                    fill_idx_d   = dcnt_q;
                    fill_data_d  = hrdata;
                    dcnt_d       = dcnt_q + ONE;
                    if (state_q == S_DRAIN) begin
                        fill_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        acnt_d = acnt_inc;
                        if (acnt_q == LAST_BEAT) begin
                            htrans_d = HTRANS_IDLE;
                            state_d  = S_DRAIN;
                        end else begin
                            haddr_d = beat_addr(base_q, acnt_inc);
                        end
                    end
                end
            end

            S_ERR: begin
                htrans_d = HTRANS_IDLE;
                if (hready && hresp) begin
                    fill_err_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                htrans_d = HTRANS_IDLE;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset abandons any burst silently.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            acnt_q     <= '0;
            dcnt_q     <= '0;
            haddr      <= '0;
            htrans     <= HTRANS_IDLE;
            miss_ack   <= 1'b0;
            fill_valid <= 1'b0;
            fill_idx   <= '0;
            fill_data  <= '0;
            fill_done  <= 1'b0;
            fill_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            acnt_q     <= acnt_d;
            dcnt_q     <= dcnt_d;
            haddr      <= haddr_d;
            htrans     <= htrans_d;
            miss_ack   <= miss_ack_d;
            fill_valid <= fill_valid_d;
            fill_idx   <= fill_idx_d;
            fill_data  <= fill_data_d;
            fill_done  <= fill_done_d;
            fill_err   <= fill_err_d;
        end
    end

endmodule

// File: tb/tb_ahb_refill_ctrl.sv
// Bench for ahb_refill_ctrl: a behavioural AHB slave returns a fixed
// per-address word pattern, a reference model turns each miss into the
// expected address list and fill sequence, and two monitors pop and compare.
module tb_ahb_refill_ctrl;

    localparam int LW = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = $clog2(LW);

    logic          clk = 1'b0;
    logic          rstn;
    logic          miss_req;
    logic [AW-1:0] miss_addr;
    logic          miss_ack;
    logic          busy;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic [2:0]    hsize;
    logic          hwrite;
    logic          hready;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic          fill_valid;
    logic [IW-1:0] fill_idx;
    logic [DW-1:0] fill_data;
    logic          fill_done;
    logic          fill_err;

    ahb_refill_ctrl #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn), .miss_req(miss_req), .miss_addr(miss_addr),
        .miss_ack(miss_ack), .busy(busy), .haddr(haddr), .htrans(htrans),
        .hburst(hburst), .hsize(hsize), .hwrite(hwrite), .hready(hready),
        .hresp(hresp), .hrdata(hrdata), .fill_valid(fill_valid),
        .fill_idx(fill_idx), .fill_data(fill_data), .fill_done(fill_done),
        .fill_err(fill_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic [31:0]   data;
        logic          done;
        logic          err;
    } fill_t;

    typedef struct {
        int err_beat;
        int wait_beat;
    } plan_t;

    fill_t       exp_fill_q[$];
    logic [32:0] exp_addr_q[$];   // bit 32 marks the NONSEQ beat
    plan_t       plan_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wait_pct = 0;
    int first_fill_cyc = -1;
    int last_done_cyc  = -1;
    int last_err_cyc   = -1;
    int done_cnt       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [2:0] exp_hburst();
        case (LW)
            4:       return 3'b011;
            8:       return 3'b101;
            default: return 3'b111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: a miss yields LW fills of consecutive line words, or the
    // words before the failing beat followed by one error event.
    task automatic issue(input logic [31:0] a, input int err_beat, input int wait_beat,
                         output int t0);
        logic [31:0] base;
        fill_t       f;
        plan_t       p;
        int          nfill;
        int          naddr;
        bit          acked;
        base  = a - (a % 32'(LW * 4));
        nfill = (err_beat >= 0) ? err_beat : LW;
        naddr = (err_beat >= 0) ? err_beat + 1 : LW;
        for (int i = 0; i < nfill; i++) begin
            f.idx  = IW'(i);
            f.data = mem_word(base + 32'(4 * i));
            f.done = (err_beat < 0) && (i == LW - 1);
            f.err  = 1'b0;
            exp_fill_q.push_back(f);
        end
        if (err_beat >= 0) begin
            f.idx = '0; f.data = '0; f.done = 1'b0; f.err = 1'b1;
            exp_fill_q.push_back(f);
        end
        for (int i = 0; i < naddr; i++)
            exp_addr_q.push_back({(i == 0), base + 32'(4 * i)});
        p.err_beat  = err_beat;
        p.wait_beat = wait_beat;
        plan_q.push_back(p);
        miss_addr = a;
        miss_req  = 1'b1;
        t0        = cyc;
        acked     = 1'b0;
        for (int k = 0; k < 100 && !acked; k++) begin
            @(posedge clk); #1;
            if (miss_ack) acked = 1'b1;
        end
        miss_req = 1'b0;
        if (!acked) chk("miss_ack_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 500 && !idle; k++) begin
            @(posedge clk); #1;
            if (!busy) idle = 1'b1;
        end
        if (!idle) chk("busy_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // Behavioural AHB slave: tracks the data phase from accepted addresses and
    // inserts planned wait states or a two-cycle ERROR response.
    initial begin : slave
        bit          dph_v;
        logic [31:0] dph_a;
        int          cur_err, cur_wait, wcnt, beat;
        bit          eph;
        bit          a_acc, a_ns, a_rdy, a_rst;
        logic [31:0] a_addr;
        plan_t       p;
        dph_v = 0; dph_a = '0; cur_err = -1; cur_wait = -1; wcnt = 0; eph = 0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        forever begin
            @(negedge clk);
            a_acc  = htrans[1] && hready;
            a_ns   = (htrans == 2'b10);
            a_rdy  = hready;
            a_rst  = rstn;
            a_addr = haddr;
            @(posedge clk); #1;
            if (!a_rst) begin
                dph_v = 0; eph = 0; cur_err = -1; cur_wait = -1;
            end else if (a_rdy) begin
                dph_v = a_acc; dph_a = a_addr; wcnt = 0; eph = 0;
                if (a_acc && a_ns) begin
                    if (plan_q.size() > 0) begin
                        p = plan_q.pop_front();
                        cur_err = p.err_beat; cur_wait = p.wait_beat;
                    end else begin
                        cur_err = -1; cur_wait = -1;
                    end
                end
            end
            beat   = int'(dph_a[IW+1:2]);
            hrdata = dph_v ? mem_word(dph_a) : $urandom;
            if (eph) begin
                hresp = 1'b1; hready = 1'b1; eph = 0; cur_err = -1;
            end else if (dph_v && beat == cur_err) begin
                hresp = 1'b1; hready = 1'b0; eph = 1;
            end else if (dph_v && beat == cur_wait && wcnt < 2) begin
                hresp = 1'b0; hready = 1'b0; wcnt++;
            end else begin
                hresp = 1'b0;
                hready = ($urandom_range(99) >= wait_pct);
            end
        end
    end

    // Monitors: fill port against the fill queue, bus against the address queue.
    always @(negedge clk) begin : mon
        fill_t       f;
        logic [32:0] e;
        if (fill_valid || fill_done || fill_err) begin
            if (exp_fill_q.size() == 0) begin
                chk("fill_unexpected", {fill_valid, fill_done, fill_err}, 0);
            end else begin
                f = exp_fill_q.pop_front();
                chk("fill_event",
                    {fill_valid, fill_done, fill_err,
                     fill_valid ? fill_idx : {IW{1'b0}}, fill_valid ? fill_data : 32'h0},
                    {~f.err, f.done, f.err, f.idx, f.data});
            end
            if (fill_valid && fill_idx == '0) first_fill_cyc = cyc;
            if (fill_done) begin last_done_cyc = cyc; done_cnt++; end
            if (fill_err) last_err_cyc = cyc;
        end
        if (htrans != 2'b00 && hready) begin
            if (exp_addr_q.size() == 0) begin
                chk("bus_unexpected", {htrans, haddr}, 0);
            end else begin
                e = exp_addr_q.pop_front();
                chk("bus_beat", {htrans, hburst, hsize, hwrite, haddr},
                    {(e[32] ? 2'b10 : 2'b11), exp_hburst(), 3'b010, 1'b0, e[31:0]});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, t1, prev_done, seen;
        rstn = 1'b0; miss_req = 1'b0; miss_addr = '0; wait_pct = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {miss_ack, busy, htrans, haddr, fill_valid, fill_idx, fill_data, fill_done, fill_err}, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Zero-wait refill of the line holding 0x1234.
        issue(32'h0000_1234, -1, -1, t0);
        chk("ack_latency", cyc - t0, 1);
        wait_idle();
        chk("first_fill_latency", first_fill_cyc - t0, 3);
        chk("done_latency", last_done_cyc - t0, LW + 2);

        // Two wait states on beat 2's data phase.
        issue(32'h0000_2468, -1, 2, t0);
        wait_idle();
        chk("done_latency_waits", last_done_cyc - t0, LW + 4);

        // ERROR on beat 1.
        prev_done = done_cnt;
        issue(32'h0000_3008, 1, -1, t0);
        repeat (3) begin @(posedge clk); #1; end
        chk("err_htrans_idle", {busy, htrans}, {1'b1, 2'b00});
        wait_idle();
        chk("err_latency", last_err_cyc - t0, 5);
        chk("no_done_on_err", done_cnt, prev_done);

        // Back-to-back: second request held across the first completion.
        issue(32'h0000_1100, -1, -1, t0);
        issue(32'h0000_2000, -1, -1, t1);
        chk("b2b_nonseq", {32'(cyc - last_done_cyc), htrans, haddr}, {32'd1, 2'b10, 32'h0000_2000});
        wait_idle();

        // Reset after beat 1 has been delivered.
        issue(32'h0000_0300, -1, -1, t0);
        seen = 0;
        for (int k = 0; k < 100 && seen == 0; k++) begin
            if (fill_valid && fill_idx == IW'(1)) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (seen == 0) chk("reset_wait_timeout", 0, 1);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("midburst_reset_outputs",
            {miss_ack, busy, htrans, haddr, fill_valid, fill_idx, fill_data, fill_done, fill_err}, 0);
        rstn = 1'b1;
        exp_fill_q.delete(); exp_addr_q.delete(); plan_q.delete();
        @(posedge clk); #1;
        issue(32'h0000_0040, -1, -1, t0);
        chk("post_reset_ack_latency", cyc - t0, 1);
        wait_idle();
        chk("post_reset_done_latency", last_done_cyc - t0, LW + 2);

        // Request pulsed while busy is dropped, not queued.
        issue(32'h0000_0500, -1, -1, t0);
        miss_addr = 32'h0000_0900;
        miss_req  = 1'b1;
        @(posedge clk); #1;
        miss_req = 1'b0;
        chk("busy_req_no_ack", miss_ack, 0);
        wait_idle();
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (miss_ack || busy) seen = 1;
        end
        chk("busy_req_not_queued", seen, 0);

        // Randomized misses with random wait states and errors.
        for (int n = 0; n < 40; n++) begin
            int eb, wb;
            wait_pct = $urandom_range(0, 40);
            eb = ($urandom_range(3) == 0) ? int'($urandom_range(LW - 1)) : -1;
            wb = ($urandom_range(1) == 0) ? int'($urandom_range(LW - 1)) : -1;
            issue($urandom, eb, wb, t0);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_pct = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("fill_queue_empty", exp_fill_q.size(), 0);
        chk("addr_queue_empty", exp_addr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
